// File: rtl/menu_select_if.sv
// Signal bundle between menu_select (master) and the pixel pipeline / main game (slave).
// The menu side takes the master modport; pipeline, game and bench take slave.
interface menu_select_if #(
  parameter int N_ITEMS = 4,
  parameter int CORDW   = 16
);
  localparam int SELW = $clog2(N_ITEMS);

  logic                    i_frame;
  logic signed [CORDW-1:0] i_sx;
  logic signed [CORDW-1:0] i_sy;
  logic [2:0]              i_key;
  logic                    i_spr_drawing;
  logic [23:0]             i_spr_color;
  logic                    i_main_ready;
  logic                    o_main_start;
  logic [SELW-1:0]         o_sel;
  logic                    o_processing;
  logic                    o_drawing;
  logic [7:0]              o_red;
  logic [7:0]              o_green;
  logic [7:0]              o_blue;
  logic [1:0]              o_dbg_state;

  // Start handshake: o_main_start acts as valid, i_main_ready as ready. Valid rises on
  // the select edge, stays high through the fade and the wait, and drops on the edge
  // where ready is sampled high in HOLD; it never drops without that transfer.
  modport master (
    input  i_frame, i_sx, i_sy, i_key, i_spr_drawing, i_spr_color, i_main_ready,
    output o_main_start, o_sel, o_processing, o_drawing, o_red, o_green, o_blue,
    output o_dbg_state
  );

  modport slave (
    output i_frame, i_sx, i_sy, i_key, i_spr_drawing, i_spr_color, i_main_ready,
    input  o_main_start, o_sel, o_processing, o_drawing, o_red, o_green, o_blue,
    input  o_dbg_state
  );
endinterface

// File: rtl/menu_select.sv
// Multi-item start menu: key-driven cursor, item/sprite rendering, confirm-triggered fade and
// start handshake with the main game. Define MENU_FADE_EN for the scaled fade; else a hard cut.
module menu_select #(
  parameter int          N_ITEMS    = 4,
  parameter int          CORDW      = 16,
  parameter int          ITEM_X     = 300,
  parameter int          ITEM_Y0    = 200,
  parameter int          ITEM_W     = 200,
  parameter int          ITEM_H     = 48,
  parameter int          FADE_STEP  = 4,
  parameter logic [23:0] BG_COLOR   = 24'h00FFFF,
  parameter logic [23:0] ITEM_COLOR = 24'h404040,
  parameter logic [23:0] HL_COLOR   = 24'hFFFF00
) (
  input  logic          i_clk_pix,
  input  logic          i_rst,
  menu_select_if.master bus
);
  localparam int SELW = $clog2(N_ITEMS);

  if (FADE_STEP < 1 || FADE_STEP > 256 || N_ITEMS < 2 || N_ITEMS > 16) begin : g_bad_param
    $error("menu_select: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_FADE, S_HOLD, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   cursor_q, cursor_d;
  logic [2:0]        key_q, press;
  logic              drawing_q, drawing_d;
  logic [23:0]       rgb_q, rgb_d;
  logic [23:0]       color;
  logic              hit_any, hit_sel;
  logic signed [CORDW-1:0] sx_c, sy_c;

`ifdef MENU_FADE_EN
  localparam logic [8:0] STEP9 = 9'(FADE_STEP);
  logic [8:0] fade_lvl_q, fade_lvl_d;
`endif

  assign sx_c  = bus.i_sx;
  assign sy_c  = bus.i_sy;
  assign press = bus.i_key & ~key_q;

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
`ifdef MENU_FADE_EN
    fade_lvl_d = fade_lvl_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (press[0]) begin
          state_d = S_FADE;
        end else if (press[1] && !press[2]) begin
          cursor_d = (cursor_q == SELW'(N_ITEMS-1)) ? '0 : cursor_q + 1'b1;
        end else if (press[2] && !press[1]) begin
          cursor_d = (cursor_q == '0) ? SELW'(N_ITEMS-1) : cursor_q - 1'b1;
        end
      end
      S_FADE: begin
`ifdef MENU_FADE_EN
        if (fade_lvl_q == 9'd0) begin
          state_d = S_HOLD;
        end else if (bus.i_frame) begin
          fade_lvl_d = (fade_lvl_q > STEP9) ? fade_lvl_q - STEP9 : 9'd0;
        end
`else
        if (bus.i_frame) state_d = S_HOLD;
`endif
      end
      S_HOLD: begin
        if (bus.i_main_ready) state_d = S_DONE;
      end
      default: ;
    endcase
  end

  // Signed compare: blanking coordinates are negative and must never hit a box.
  always_comb begin
    int sx, sy, top;
    sx      = int'(sx_c);
    sy      = int'(sy_c);
    top     = 0;
    hit_any = 1'b0;
    hit_sel = 1'b0;
    for (int k = 0; k < N_ITEMS; k++) begin
      top = ITEM_Y0 + k * ITEM_H;
      if (sx >= ITEM_X && sx < ITEM_X + ITEM_W && sy >= top && sy < top + ITEM_H - 4) begin
        hit_any = 1'b1;
        if (cursor_q == SELW'(k)) hit_sel = 1'b1;
      end
    end

    if (bus.i_spr_drawing) color = bus.i_spr_color;
    else if (hit_sel)      color = HL_COLOR;
    else if (hit_any)      color = ITEM_COLOR;
    else                   color = BG_COLOR;

    drawing_d = (state_q != S_DONE) && (bus.i_spr_drawing || hit_any);
`ifdef MENU_FADE_EN
    rgb_d[23:16] = 8'((16'(color[23:16]) * 16'(fade_lvl_q)) >> 8);
    rgb_d[15:8]  = 8'((16'(color[15:8])  * 16'(fade_lvl_q)) >> 8);
    rgb_d[7:0]   = 8'((16'(color[7:0])   * 16'(fade_lvl_q)) >> 8);
`else
    rgb_d = (state_q == S_HOLD || state_q == S_DONE) ? 24'd0 : color;
`endif
    if (state_q == S_DONE) rgb_d = 24'd0;
  end

  always_ff @(posedge i_clk_pix or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cursor_q  <= '0;
      key_q     <= '0;
      drawing_q <= 1'b0;
      rgb_q     <= '0;
`ifdef MENU_FADE_EN
      fade_lvl_q <= 9'd256;
`endif
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      key_q     <= bus.i_key;
      drawing_q <= drawing_d;
      rgb_q     <= rgb_d;
`ifdef MENU_FADE_EN
      fade_lvl_q <= fade_lvl_d;
`endif
    end
  end

  // Gating on the live state blanks the registered pixel on the very edge DONE is entered.
  assign bus.o_main_start = (state_q == S_FADE) || (state_q == S_HOLD);
  assign bus.o_sel        = cursor_q;
  assign bus.o_processing = (state_q != S_DONE);
  assign bus.o_drawing    = drawing_q && (state_q != S_DONE);
  assign bus.o_red        = (state_q == S_DONE) ? 8'd0 : rgb_q[23:16];
  assign bus.o_green      = (state_q == S_DONE) ? 8'd0 : rgb_q[15:8];
  assign bus.o_blue       = (state_q == S_DONE) ? 8'd0 : rgb_q[7:0];
  assign bus.o_dbg_state  = state_q;
endmodule

// File: tb/tb_menu_select.sv
// Bench for menu_select: table-driven pixel vectors, hand-written navigation/fade/handshake
// sequences, and randomized episodes checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_menu_select;
  localparam int N = 4, X0 = 300, Y0 = 200, W = 200, H = 48, STEP = 4;
  localparam logic [23:0] BG = 24'h00FFFF, IC = 24'h404040, HL = 24'hFFFF00;
`ifdef MENU_FADE_EN
  localparam int FADE_FRAMES = (256 + STEP - 1) / STEP;
  localparam int HOLD_LAG    = 1;
`else
  localparam int FADE_FRAMES = 1;
  localparam int HOLD_LAG    = 0;
`endif
  localparam int M_IDLE = 0, M_FADE = 1, M_HOLD = 2, M_DONE = 3;

  typedef struct {
    int          x;
    int          y;
    bit          spr;
    logic [23:0] spr_col;
    bit          exp_draw;
    logic [23:0] exp_rgb;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  menu_select_if #(.N_ITEMS(N), .CORDW(16)) bus ();

  menu_select #(
    .N_ITEMS(N), .CORDW(16), .ITEM_X(X0), .ITEM_Y0(Y0), .ITEM_W(W), .ITEM_H(H),
    .FADE_STEP(STEP), .BG_COLOR(BG), .ITEM_COLOR(IC), .HL_COLOR(HL)
  ) dut (
    .i_clk_pix(clk),
    .i_rst    (rst),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int px = 0, py = 0;

  // ---------------- reference model ----------------
  int         m_state, m_cursor, m_fade;
  logic [2:0] m_keyq;
  logic [23:0] exp_q[$];

  function automatic logic [24:0] ref_pixel(int x, int y, bit spr, logic [23:0] sc, int cur);
    int row;
    bit hit, sel;
    hit = 0;
    sel = 0;
    row = 0;
    if (x >= X0 && x < X0 + W && y >= Y0) begin
      row = (y - Y0) / H;
      hit = (row < N) && (((y - Y0) % H) < H - 4);
      sel = hit && (row == cur);
    end
    if (spr) return {1'b1, sc};
    if (sel) return {1'b1, HL};
    if (hit) return {1'b1, IC};
    return {1'b0, BG};
  endfunction

  function automatic logic [23:0] scale(logic [23:0] c, int f);
    int r, g, b;
    r = int'(c[23:16]) * f / 256;
    g = int'(c[15:8])  * f / 256;
    b = int'(c[7:0])   * f / 256;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] dut_rgb();
    return {bus.o_red, bus.o_green, bus.o_blue};
  endfunction

  // One clock: inputs already set are sampled on the edge; model advances; outputs compared.
  task automatic tick();
    logic [2:0]  press;
    logic [24:0] pix;
    logic [23:0] col;
    bit          drw;
    logic [28:0] act, exp;
    @(posedge clk);
    #1;
    press = bus.i_key & ~m_keyq;
    pix   = ref_pixel(px, py, bus.i_spr_drawing, bus.i_spr_color, m_cursor);
    drw   = pix[24];
    col   = pix[23:0];
`ifdef MENU_FADE_EN
    col = scale(col, m_fade);
`else
    if (m_state == M_HOLD || m_state == M_DONE) col = '0;
`endif
    case (m_state)
      M_IDLE: begin
        if (press[0]) m_state = M_FADE;
        else if (press[1] && !press[2]) m_cursor = (m_cursor + 1) % N;
        else if (press[2] && !press[1]) m_cursor = (m_cursor + N - 1) % N;
      end
      M_FADE: begin
`ifdef MENU_FADE_EN
        if (m_fade == 0) m_state = M_HOLD;
        else if (bus.i_frame) m_fade = (m_fade > STEP) ? m_fade - STEP : 0;
`else
        if (bus.i_frame) m_state = M_HOLD;
`endif
      end
      M_HOLD: if (bus.i_main_ready) m_state = M_DONE;
      default: ;
    endcase
    m_keyq = bus.i_key;
    if (m_state == M_DONE) begin
      drw = 0;
      col = '0;
    end
    exp_q.push_back(col);
    exp = {(m_state == M_FADE || m_state == M_HOLD), 2'(m_cursor), (m_state != M_DONE), drw,
           exp_q.pop_front()};
    act = {bus.o_main_start, bus.o_sel, bus.o_processing, bus.o_drawing, dut_rgb()};
    check("cycle", 32'(act), 32'(exp));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_pix(input int x, input int y);
    px = x;
    py = y;
    bus.i_sx = 16'(x);
    bus.i_sy = 16'(y);
  endtask

  task automatic check_reset_vals();
    check("rst_main_start", 32'(bus.o_main_start), 0);
    check("rst_sel",        32'(bus.o_sel), 0);
    check("rst_processing", 32'(bus.o_processing), 1);
    check("rst_drawing",    32'(bus.o_drawing), 0);
    check("rst_rgb",        32'(dut_rgb()), 0);
  endtask

  // Raises reset between edges, checks the asynchronous effect, releases after one edge.
  task automatic apply_reset();
    bus.i_key = '0;
    bus.i_frame = 1'b0;
    bus.i_main_ready = 1'b0;
    bus.i_spr_drawing = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_vals();
    m_state  = M_IDLE;
    m_cursor = 0;
    m_fade   = 256;
    m_keyq   = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic press_key(input logic [2:0] k);
    bus.i_key = k;
    tick();
    bus.i_key = '0;
    tick();
  endtask

  task automatic pulse_frame();
    bus.i_frame = 1'b1;
    tick();
    bus.i_frame = 1'b0;
    tick();
  endtask

  // ---------------- test ----------------
  vec_t vecs[14];

  initial begin
    vecs[0]  = '{300, 200, 1'b0, 24'h0,      1'b1, HL};
    vecs[1]  = '{499, 243, 1'b0, 24'h0,      1'b1, HL};
    vecs[2]  = '{299, 200, 1'b0, 24'h0,      1'b0, BG};
    vecs[3]  = '{500, 200, 1'b0, 24'h0,      1'b0, BG};
    vecs[4]  = '{300, 244, 1'b0, 24'h0,      1'b0, BG};
    vecs[5]  = '{300, 248, 1'b0, 24'h0,      1'b1, IC};
    vecs[6]  = '{400, 387, 1'b0, 24'h0,      1'b1, IC};
    vecs[7]  = '{400, 388, 1'b0, 24'h0,      1'b0, BG};
    vecs[8]  = '{400, 392, 1'b0, 24'h0,      1'b0, BG};
    vecs[9]  = '{-5,  -5,  1'b0, 24'h0,      1'b0, BG};
    vecs[10] = '{300, 199, 1'b0, 24'h0,      1'b0, BG};
    vecs[11] = '{-1,  200, 1'b0, 24'h0,      1'b0, BG};
    vecs[12] = '{10,  10,  1'b1, 24'h123456, 1'b1, 24'h123456};
    vecs[13] = '{300, 200, 1'b1, 24'hABCDEF, 1'b1, 24'hABCDEF};

    bus.i_spr_color = '0;
    set_pix(0, 0);
    apply_reset();

    // Pixel classification at cursor 0, full brightness
    for (int i = 0; i < 14; i++) begin
      set_pix(vecs[i].x, vecs[i].y);
      bus.i_spr_drawing = vecs[i].spr;
      bus.i_spr_color   = vecs[i].spr_col;
      tick();
      check($sformatf("vec%0d_draw", i), 32'(bus.o_drawing), 32'(vecs[i].exp_draw));
      check($sformatf("vec%0d_rgb", i),  32'(dut_rgb()),     32'(vecs[i].exp_rgb));
    end
    bus.i_spr_drawing = 1'b0;

    // Navigate down twice
    press_key(3'b010);
    press_key(3'b010);
    check("nav_sel", 32'(bus.o_sel), 2);
    set_pix(300, 296);
    tick();
    check("nav_hl", 32'(dut_rgb()), 32'(HL));
    set_pix(300, 200);
    tick();
    check("nav_item", 32'(dut_rgb()), 32'(IC));

    // Wrap-around and held key
    apply_reset();
    press_key(3'b100);
    check("wrap_up", 32'(bus.o_sel), 3);
    press_key(3'b010);
    check("wrap_down", 32'(bus.o_sel), 0);
    bus.i_key = 3'b010;
    repeat (100) tick();
    bus.i_key = '0;
    tick();
    check("held_down", 32'(bus.o_sel), 1);

    // Up+down together: no move
    press_key(3'b110);
    check("updown_nomove", 32'(bus.o_sel), 1);

    // Select with up+down, coincident with a frame; ready held low (late ready)
    set_pix(300, 248);
    bus.i_key = 3'b111;
    bus.i_frame = 1'b1;
    tick();
    bus.i_frame = 1'b0;
    check("prio_start", 32'(bus.o_main_start), 1);
    check("prio_sel", 32'(bus.o_sel), 1);
    bus.i_key = '0;
    tick();
    repeat (FADE_FRAMES - 1) pulse_frame();
    press_key(3'b010);
    check("fade_sel_frozen", 32'(bus.o_sel), 1);
    check("fade_not_dark_yet", 32'(dut_rgb() != 24'd0), 1);
    pulse_frame();
    check("hold_rgb", 32'(dut_rgb()), 0);
    check("hold_start", 32'(bus.o_main_start), 1);
    check("hold_processing", 32'(bus.o_processing), 1);
    repeat (40) pulse_frame();
    check("late_start", 32'(bus.o_main_start), 1);
    check("late_rgb", 32'(dut_rgb()), 0);
    bus.i_main_ready = 1'b1;
    tick();
    check("done_start", 32'(bus.o_main_start), 0);
    check("done_processing", 32'(bus.o_processing), 0);
    check("done_drawing", 32'(bus.o_drawing), 0);
    bus.i_main_ready = 1'b0;
    press_key(3'b100);
    check("done_keys_ignored", 32'(bus.o_sel), 1);

    // Start with ready high throughout
    apply_reset();
    set_pix(300, 200);
    bus.i_main_ready = 1'b1;
    bus.i_key = 3'b001;
    tick();
    check("go_start", 32'(bus.o_main_start), 1);
    bus.i_key = '0;
    tick();
    repeat (FADE_FRAMES - 1) pulse_frame();
    bus.i_frame = 1'b1;
    tick();
    bus.i_frame = 1'b0;
    repeat (HOLD_LAG) tick();
    check("go_hold_start", 32'(bus.o_main_start), 1);
    tick();
    check("go_done_start", 32'(bus.o_main_start), 0);
    check("go_done_processing", 32'(bus.o_processing), 0);

    // Reset mid-fade
    apply_reset();
    set_pix(300, 200);
    bus.i_key = 3'b001;
    tick();
    bus.i_key = '0;
    tick();
`ifdef MENU_FADE_EN
    repeat (32) pulse_frame();
    check("half_fade_rgb", 32'(dut_rgb()), 32'h7F7F00);
`endif
    apply_reset();
    set_pix(300, 200);
    tick();
    check("post_reset_full", 32'(dut_rgb()), 32'(HL));

    // Randomized episodes against the model
    for (int ep = 0; ep < 5; ep++) begin
      apply_reset();
      for (int c = 0; c < 500; c++) begin
        logic [2:0] k;
        k[0] = ($urandom_range(0, 29) == 0);
        k[1] = ($urandom_range(0, 2) == 0);
        k[2] = ($urandom_range(0, 2) == 0);
        bus.i_key         = k;
        bus.i_frame       = ($urandom_range(0, 3) == 0);
        bus.i_main_ready  = ($urandom_range(0, 7) == 0);
        bus.i_spr_drawing = ($urandom_range(0, 9) == 0);
        bus.i_spr_color   = 24'($urandom);
        set_pix(int'($urandom_range(280, 520)), int'($urandom_range(0, 420)) - 20);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/menu_select.md
# menu_select

Multi-item start menu for the pixel pipeline, replacing the single-button title screen. Renders N_ITEMS stacked selectable boxes with a highlighted cursor moved by keys, overlays an external sprite, and on confirm runs a frame-timed fade-out while handshaking with the main game (`o_main_start` / `i_main_ready`). It sits beside the main game renderer; its colour outputs feed the top-level pixel mux while `o_processing` is high.

## Interface
- `N_ITEMS`, 4: number of menu entries (2..16).
- `CORDW`, 16: signed screen-coordinate width.
- `ITEM_X`, 300: left edge of all item boxes.
- `ITEM_Y0`, 200: top edge of item 0.
- `ITEM_W`, 200: box width in pixels.
- `ITEM_H`, 48: vertical pitch; each box is `ITEM_H-4` tall.
- `FADE_STEP`, 4: fade decrement per frame (1..256).
- `BG_COLOR`, 24'h00FFFF: background.
- `ITEM_COLOR`, 24'h404040: unselected box.
- `HL_COLOR`, 24'hFFFF00: selected box.

Ports:
- `i_clk_pix` in, 1: pixel clock.
- `i_rst` in, 1: asynchronous, active-high reset.
- `i_frame` in, 1: one-cycle pulse at frame start.
- `i_sx`, `i_sy` in, CORDW signed: current pixel.
- `i_key` in, 3: level keys, pre-synchronised; [0] select, [1] down, [2] up.
- `i_spr_drawing` in, 1: sprite pixel opaque at (`i_sx`, `i_sy`).
- `i_spr_color` in, 24: sprite colour {R,G,B}.
- `i_main_ready` in, 1: main game ready to take over.
- `o_main_start` out, 1: start request to main game.
- `o_sel` out, $clog2(N_ITEMS): cursor / chosen item.
- `o_processing` out, 1: menu owns the screen.
- `o_drawing` out, 1: menu pixel is non-background.
- `o_red`, `o_green`, `o_blue` out, 8 each.

## Operation
- Key edge detect: `key_q <= i_key` every cycle; press = `i_key & ~key_q`. Holding a key yields one press.
- States: IDLE, FADE, HOLD, DONE.
- IDLE:
  - Select press goes to FADE; it has priority over moves in the same cycle.
  - Else a down press alone increments the cursor, wrapping N_ITEMS-1 to 0.
  - An up press alone decrements the cursor, wrapping 0 to N_ITEMS-1.
  - Up and down together: no move.
- FADE: on each `i_frame`, `fade_lvl` (9-bit, 0..256) decreases by FADE_STEP, saturating at 0. When `fade_lvl` is 0, go to HOLD.
- HOLD: go to DONE when `i_main_ready` is high. It can be high on the first HOLD cycle.
- DONE: sticky until reset. Keys are ignored in every state except IDLE.
- `o_main_start` = state in {FADE, HOLD}.
- `o_processing` = state != DONE.
- `o_sel` = cursor; it is frozen from FADE onward.
- Pixel classification: item k is hit when `ITEM_X <= i_sx < ITEM_X+ITEM_W` and `ITEM_Y0+k*ITEM_H <= i_sy < ITEM_Y0+k*ITEM_H+ITEM_H-4`. Coordinates are compared signed, so negative blanking coordinates never hit.
- Colour priority: sprite, then selected item (HL_COLOR), then other item (ITEM_COLOR), then BG_COLOR.
- `o_drawing` = sprite or any item hit.
- Fade scaling: each channel = (c * fade_lvl) >> 8. The product is 17 bits; take bits [15:8] at fade_lvl = 256, which passes c exactly.
- In DONE: `o_drawing` = 0 and rgb = 0.

## Timing
- Async reset: state IDLE, cursor 0, `fade_lvl` 256, `key_q` 0.
- Output values during reset: `o_main_start` 0, `o_sel` 0, `o_processing` 1, `o_drawing` 0, rgb 0.
- Reset mid-operation aborts immediately to the reset values above.
- Key response: state and cursor update on the same clock edge that first samples the key high. `o_main_start` is high right after that edge.
- Pixel path: one register stage. `o_drawing` and rgb for (`i_sx`, `i_sy`) appear one cycle after the coordinate.
- Fade timing: fade takes ceil(256/FADE_STEP) `i_frame` pulses. FADE goes to HOLD on the edge after `fade_lvl` becomes 0.
- `o_main_start` falls on the edge entering DONE. `o_processing` falls on the same edge.
- If `i_frame` coincides with a select press, the first decrement happens on the next `i_frame`, not that one.

## Configuration
- `MENU_FADE_EN` defined: fade arithmetic as above.
- `MENU_FADE_EN` undefined: no multiplier and no `fade_lvl` register.
  - FADE lasts until the first `i_frame` after entry, then goes to HOLD (hard cut).
  - Colours are unscaled in IDLE and FADE.
  - rgb = 0 in HOLD and DONE.
  - All other behaviour is unchanged.

## Test plan
- Navigate down: reset, two down presses -> `o_sel`=2. Pixel (300,296) -> HL_COLOR one cycle later; (300,200) -> ITEM_COLOR.
- Wrap-around: up press at cursor 0 -> `o_sel`=3; then a down press -> `o_sel`=0. Holding down for 100 cycles -> single increment.
- Start, ready high: select with FADE_STEP=4 -> `o_main_start` rises the next cycle. Colours reach 0 after 64 `i_frame` pulses. DONE is reached via HOLD, with `o_main_start`=0 and `o_processing`=0 on the same edge.
- Late ready: fade done while `i_main_ready`=0 for 40 frames -> stays in HOLD with rgb=0 and `o_main_start`=1. DONE follows the edge after ready rises.
- Priority: up+down+select rising together at cursor 1 -> FADE with `o_sel`=1. Up+down alone -> cursor unchanged.
- Reset mid-fade: assert `i_rst` at `fade_lvl`=128 -> outputs immediately return to reset values. After release, full brightness in IDLE.
